// File: rtl/linear_network_mcast_seq.sv
// rtl/linear_network_mcast_seq.sv - registered hop chain fanning one stream out to NUM_NODE ports (unicast/multicast/broadcast)
module linear_network_mcast_seq #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_NODE        = 16,
  parameter int NODES_PER_STAGE = 1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data_bus,
  input  logic [1:0]                     i_mode,
  input  logic [NUM_NODE-1:0]            i_cmd,
  output logic [NUM_NODE-1:0]            o_valid,
  output logic [DATA_WIDTH*NUM_NODE-1:0] o_data_bus,
  output logic [CNT_WIDTH-1:0]           o_drop_cnt
);

  localparam int NUM_STAGE = (NUM_NODE + NODES_PER_STAGE - 1) / NODES_PER_STAGE;

  logic [NUM_NODE-1:0]            uni_mask;
  logic [NUM_NODE-1:0]            dec_mask;
  logic [NUM_NODE-1:0]            node_valid_d;
  logic [DATA_WIDTH*NUM_NODE-1:0] node_data_d;
  logic [NUM_NODE-1:0]            out_valid_q;
  logic [DATA_WIDTH*NUM_NODE-1:0] out_data_q;
  logic [CNT_WIDTH-1:0]           drop_cnt_q;
  logic [CNT_WIDTH-1:0]           drop_cnt_d;
  logic                           drop;

  // Unicast index is the whole command word, so any out-of-range value decodes to no destination.
  for (genvar k = 0; k < NUM_NODE; k++) begin : g_uni
    assign uni_mask[k] = (i_cmd == NUM_NODE'(k));
  end

  always_comb begin
    dec_mask = '0;
    case (i_mode)
      2'b00:   dec_mask = uni_mask;
      2'b01:   dec_mask = i_cmd;
      2'b10:   dec_mask = '1;
      default: dec_mask = '0;
    endcase
  end

  // Each hop keeps only the mask bits of its own nodes and those downstream; the rest were consumed upstream.
  for (genvar h = 0; h < NUM_STAGE; h++) begin : g_stage
    localparam int LO = h * NODES_PER_STAGE;
    localparam int W  = NUM_NODE - LO;
    localparam int NL = (W < NODES_PER_STAGE) ? W : NODES_PER_STAGE;

    logic                  valid_q;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [W-1:0]          mask_q;
    logic [W-1:0]          mask_d;

    if (h == 0) begin : g_head
      assign valid_d = i_valid;
      assign data_d  = i_data_bus;
      assign mask_d  = dec_mask;
    end else begin : g_link
      assign valid_d = g_stage[h-1].valid_q;
      assign data_d  = g_stage[h-1].data_q;
      assign mask_d  = g_stage[h-1].mask_q[W+NODES_PER_STAGE-1:NODES_PER_STAGE];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        mask_q  <= '0;
      end else if (i_en) begin
        valid_q <= valid_d;
        data_q  <= data_d;
        mask_q  <= mask_d;
      end
    end

    for (genvar j = 0; j < NL; j++) begin : g_node
      assign node_valid_d[LO+j] = valid_q & mask_q[j];
      assign node_data_d[(LO+j)*DATA_WIDTH +: DATA_WIDTH] = node_valid_d[LO+j] ? data_q : '0;
    end
  end

  assign drop       = i_en & i_valid & ~|dec_mask;
  assign drop_cnt_d = (drop && !(&drop_cnt_q)) ? drop_cnt_q + CNT_WIDTH'(1) : drop_cnt_q;

  // A disabled edge blanks the outputs while the hops hold, so nothing is delivered twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= i_en ? node_valid_d : '0;
      out_data_q  <= i_en ? node_data_d : '0;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_valid    = out_valid_q;
  assign o_data_bus = out_data_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule
